// File: rtl/pipe_fetch_pkg.sv
// pipe_fetch_pkg: shared CPU constants for next-PC select, fetch FSM states and NOP
package pipe_fetch_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic {FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/pipe_fetch_if.sv
// pipe_fetch_if: instruction-memory request/acknowledge bus
interface pipe_fetch_if;
  logic req;
  logic [31:0] addr;
  logic ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/pipe_npc_mux.sv
// pipe_npc_mux: redirect target select with pending-redirect priority
module pipe_npc_mux
  import pipe_fetch_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] pc4,
  input  logic        pend_valid,
  input  logic [31:0] pend_pc,
  output logic [31:0] target,
  output logic [31:0] npc
);
  // 4:1 target select; the sequential case falls back to pc+4
  always_comb begin
    target = pcsource == PCSRC_BR ? bpc :
             pcsource == PCSRC_JR ? rpc :
             pcsource == PCSRC_J  ? jpc : pc4;
  end
  // npc is only consumed on a handover, where wpcir is already 1
  assign npc = pend_valid ? pend_pc : (pcsource != PCSRC_SEQ ? target : pc4);
endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: IF stage owning the PC, the imem handshake and the stall buffer
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  pipe_fetch_if.master imem,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        if_valid
);
  fetch_state_t state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic [31:0] npc;
  logic        pend_valid;
  logic        handover;
  logic        redirect;
  assign imem.req  = state == FETCH;
  assign imem.addr = pc;
  assign pc4       = pc + 32'd4;
  assign if_valid  = (state == FETCH && imem.ack) || state == HOLD;
  assign ins       = state == HOLD ? hold_word : (imem.ack ? imem.rdata : NOP);
  assign handover  = if_valid && wpcir;
  assign redirect  = wpcir && pcsource != PCSRC_SEQ;
  pipe_npc_mux u_npc (
    .pcsource  (pcsource),
    .bpc       (bpc),
    .rpc       (rpc),
    .jpc       (jpc),
    .pc4       (pc4),
    .pend_valid(pend_valid),
    .pend_pc   (pend_pc),
    .target    (target),
    .npc       (npc)
  );
  // Fetch FSM: advance PC on handover, park a stalled word, remember a redirect seen before its delay slot
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_word  <= NOP;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else if (handover) begin
      state      <= FETCH;
      pc         <= npc;
      pend_valid <= 1'b0;
    end else begin
      if (redirect) begin
        pend_valid <= 1'b1;
        pend_pc    <= target;
      end
      if (state == FETCH && imem.ack) begin
        hold_word <= imem.rdata;
        state     <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed table, reset and randomized model checks for pipe_fetch
module tb_pipe_fetch;
  localparam logic [31:0] RPC0 = 32'h0;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic wpcir = 1'b0;
  logic [1:0] pcsource = 2'b00;
  logic [31:0] bpc = 32'h40;
  logic [31:0] rpc = 32'h80;
  logic [31:0] jpc = 32'hFFFF_FFFC;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic if_valid;
  int compared = 0;
  int mismatched = 0;
  pipe_fetch_if imem ();
  pipe_fetch #(.RESET_PC(RPC0)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .wpcir   (wpcir),
    .pcsource(pcsource),
    .bpc     (bpc),
    .rpc     (rpc),
    .jpc     (jpc),
    .imem    (imem),
    .pc4     (pc4),
    .ins     (ins),
    .if_valid(if_valid)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic w;
    logic a;
    logic junk;
    logic [1:0] ps;
    logic [31:0] addr;
    logic req;
    logic valid;
  } vec_t;
  vec_t tbl [25];
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hDEAD_0001;
  endfunction
  function automatic vec_t mk(logic w, logic a, logic junk, logic [1:0] ps, logic [31:0] addr, logic req, logic valid);
    vec_t v;
    v.w = w; v.a = a; v.junk = junk; v.ps = ps; v.addr = addr; v.req = req; v.valid = valid;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(string tag, logic [31:0] e_addr, logic e_req, logic e_valid, logic [31:0] e_ins);
    chk({tag, " addr"}, imem.addr, e_addr);
    chk({tag, " req"}, 32'(imem.req), 32'(e_req));
    chk({tag, " valid"}, 32'(if_valid), 32'(e_valid));
    chk({tag, " ins"}, ins, e_ins);
    chk({tag, " pc4"}, pc4, e_addr + 32'd4);
  endtask
  logic [31:0] m_pc, m_ppc, tgt, e_ins;
  logic m_held, m_pend, v, take, redir;
  int cnt, wait_n;
  initial begin
    tbl[0]  = mk(1, 1, 0, 2'd0, 32'h00, 1, 1);
    tbl[1]  = mk(1, 1, 0, 2'd0, 32'h04, 1, 1);
    tbl[2]  = mk(1, 1, 0, 2'd0, 32'h08, 1, 1);
    tbl[3]  = mk(1, 1, 0, 2'd0, 32'h0C, 1, 1);
    tbl[4]  = mk(1, 0, 0, 2'd0, 32'h10, 1, 0);
    tbl[5]  = mk(1, 0, 0, 2'd0, 32'h10, 1, 0);
    tbl[6]  = mk(1, 1, 0, 2'd0, 32'h10, 1, 1);
    tbl[7]  = mk(0, 1, 0, 2'd1, 32'h14, 1, 1);
    tbl[8]  = mk(0, 0, 0, 2'd0, 32'h14, 0, 1);
    tbl[9]  = mk(0, 1, 1, 2'd0, 32'h14, 0, 1);
    tbl[10] = mk(1, 0, 0, 2'd0, 32'h14, 0, 1);
    tbl[11] = mk(1, 1, 0, 2'd0, 32'h18, 1, 1);
    tbl[12] = mk(1, 1, 0, 2'd1, 32'h1C, 1, 1);
    tbl[13] = mk(1, 1, 0, 2'd0, 32'h40, 1, 1);
    tbl[14] = mk(1, 0, 0, 2'd2, 32'h44, 1, 0);
    tbl[15] = mk(1, 0, 0, 2'd0, 32'h44, 1, 0);
    tbl[16] = mk(1, 1, 0, 2'd0, 32'h44, 1, 1);
    tbl[17] = mk(1, 1, 0, 2'd0, 32'h80, 1, 1);
    tbl[18] = mk(0, 1, 0, 2'd0, 32'h84, 1, 1);
    tbl[19] = mk(1, 0, 0, 2'd3, 32'h84, 0, 1);
    tbl[20] = mk(1, 1, 0, 2'd0, 32'hFFFF_FFFC, 1, 1);
    tbl[21] = mk(1, 0, 0, 2'd1, 32'h00, 1, 0);
    tbl[22] = mk(0, 1, 0, 2'd0, 32'h00, 1, 1);
    tbl[23] = mk(1, 0, 0, 2'd0, 32'h00, 0, 1);
    tbl[24] = mk(1, 1, 0, 2'd0, 32'h40, 1, 1);
    imem.ack = 1'b0;
    imem.rdata = 32'h0;
    #2;
    chk_out("reset", RPC0, 1'b1, 1'b0, 32'h0);
    @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wpcir = tbl[i].w;
      pcsource = tbl[i].ps;
      imem.ack = tbl[i].a;
      imem.rdata = tbl[i].junk ? 32'hBAD0_0BAD : mem_word(tbl[i].addr);
      #3;
      chk_out($sformatf("row%0d", i), tbl[i].addr, tbl[i].req, tbl[i].valid,
              tbl[i].valid ? mem_word(tbl[i].addr) : 32'h0);
      @(posedge clock);
      #1;
    end
    wpcir = 1'b1;
    pcsource = 2'd0;
    imem.ack = 1'b0;
    #3;
    chk_out("pre-reset", 32'h44, 1'b1, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    chk_out("async-reset", RPC0, 1'b1, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    chk_out("held-reset", RPC0, 1'b1, 1'b0, 32'h0);
    resetn = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = mem_word(RPC0);
    #3;
    chk_out("restart0", RPC0, 1'b1, 1'b1, mem_word(RPC0));
    @(posedge clock);
    #1;
    imem.rdata = mem_word(RPC0 + 32'd4);
    #3;
    chk_out("restart1", RPC0 + 32'd4, 1'b1, 1'b1, mem_word(RPC0 + 32'd4));
    imem.ack = 1'b0;
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    m_pc = RPC0;
    m_held = 1'b0;
    m_pend = 1'b0;
    m_ppc = 32'h0;
    cnt = 0;
    wait_n = $urandom_range(0, 3);
    for (int n = 0; n < 3000; n++) begin
      wpcir = $urandom_range(0, 9) < 7;
      pcsource = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      bpc = $urandom() & 32'hFFFF_FFFC;
      rpc = $urandom() & 32'hFFFF_FFFC;
      jpc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      imem.ack = m_held ? $urandom_range(0, 7) == 0 : cnt >= wait_n;
      imem.rdata = m_held ? $urandom() : mem_word(m_pc);
      #3;
      v = m_held || imem.ack;
      e_ins = m_held ? mem_word(m_pc) : (imem.ack ? mem_word(m_pc) : 32'h0);
      chk_out($sformatf("rand%0d", n), m_pc, !m_held, v, e_ins);
      tgt = pcsource == 2'd1 ? bpc : pcsource == 2'd2 ? rpc : jpc;
      take = v && wpcir;
      redir = wpcir && pcsource != 2'd0;
      if (!m_held) begin
        cnt = imem.ack ? 0 : cnt + 1;
        if (imem.ack) wait_n = $urandom_range(0, 3);
      end
      if (take) begin
        m_pc = m_pend ? m_ppc : (redir ? tgt : m_pc + 32'd4);
        m_pend = 1'b0;
        m_held = 1'b0;
      end else begin
        if (redir) begin
          m_pend = 1'b1;
          m_ppc = tgt;
        end
        if (imem.ack && !m_held) m_held = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
